// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared definitions for the ID-stage branch redirect controller.
// Contents: PC-select encodings, FSM state encoding, default stall limit.
package branch_redirect_ctrl_pkg;

  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0] PC_SEL_JUMP   = 2'b01;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b10;
  localparam logic [1:0] PC_SEL_JR     = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STALL    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_MAX_STALL = 3;

endpackage

// File: rtl/branch_operand_hazard.sv
// Combinational source-operand hazard detect for an ID-stage control transfer.
// Ports:
//   id_xfer, id_uses_rt, id_rs, id_rt : ID instruction and its source registers
//   ex_reg_write, ex_dst              : EX-stage producer (ALU or load)
//   mem_mem_read, mem_dst             : MEM-stage load
//   hazard                            : operand not yet available to ID
// ALU results sitting in MEM are forwarded to ID, so only loads hazard there.
// Register 0 never hazards.
module branch_operand_hazard #(
  parameter int unsigned REG_W = 5
) (
  input  logic             id_xfer,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_reg_write,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             mem_mem_read,
  input  logic [REG_W-1:0] mem_dst,
  output logic             hazard
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (|id_rs) &&
                  ((ex_reg_write && (ex_dst == id_rs)) || (mem_mem_read && (mem_dst == id_rs)));
  assign rt_hit = (|id_rt) &&
                  ((ex_reg_write && (ex_dst == id_rt)) || (mem_mem_read && (mem_dst == id_rt)));

  assign hazard = id_xfer && (rs_hit || (id_uses_rt && rt_hit));

endmodule

// File: rtl/branch_redirect_ctrl.sv
// ID-stage branch/jump redirect sequencing controller.
// Stalls the front end while a branch/jr operand is unavailable, latches the
// resolved PC-select code and target, then issues a one-cycle redirect that
// flushes IF/ID and bubbles ID/EX.
// Ports:
//   Clk, Reset                      : clock, async active-high reset
//   id_*, ex_*, mem_*               : ID transfer info and producer fields
//   pc_sel, redirect_target         : PC mux select and latched target
//   pc_write, ifid_write            : PC / IF-ID enables (low while stalling)
//   ifid_flush, idex_bubble         : pipeline clear / NOP insert
//   stall_err                       : sticky, a stall lasted MAX_STALL cycles
//   redirect_cnt, stall_cyc_cnt     : saturating statistics
// Optional macro BRANCH_STATS_EN: enables the statistics counters; when undefined
// the counter outputs are tied to zero and no counter flops exist.
// MAX_STALL must be at least 1.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned MAX_STALL = DEFAULT_MAX_STALL,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned REG_W     = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             id_xfer,
  input  logic [1:0]       id_sel_op,
  input  logic [31:0]      id_target,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_reg_write,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             mem_mem_read,
  input  logic [REG_W-1:0] mem_dst,
  output logic [1:0]       pc_sel,
  output logic [31:0]      redirect_target,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             stall_err,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cyc_cnt
);

  localparam int unsigned     SN_W   = $clog2(MAX_STALL + 1);
  localparam logic [SN_W-1:0] SN_MAX = SN_W'(MAX_STALL);

  state_t          state;
  logic [1:0]      sel_reg;
  logic [SN_W-1:0] stall_n;
  logic [SN_W-1:0] stall_n_nxt;
  logic            hazard;
  logic            stall_now;

  branch_operand_hazard #(
    .REG_W(REG_W)
  ) u_hazard (
    .id_xfer     (id_xfer),
    .id_uses_rt  (id_uses_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_reg_write(ex_reg_write),
    .ex_dst      (ex_dst),
    .mem_mem_read(mem_mem_read),
    .mem_dst     (mem_dst),
    .hazard      (hazard)
  );

  // id_* is wrong-path during REDIRECT, so a hazard there is ignored.
  assign stall_now = (state != REDIRECT) && hazard;

  // Stall length including the current cycle, saturating at MAX_STALL.
  always_comb begin
    stall_n_nxt = SN_W'(1);
    if (state == STALL) begin
      stall_n_nxt = (stall_n == SN_MAX) ? stall_n : stall_n + 1'b1;
    end
  end

  // Stall outputs are Mealy on hazard; Reset forces the reset values at once.
  always_comb begin
    pc_sel      = PC_SEL_SEQ;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!Reset) begin
      if (state == REDIRECT) begin
        pc_sel      = sel_reg;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (stall_now) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state           <= IDLE;
      sel_reg         <= PC_SEL_SEQ;
      redirect_target <= '0;
      stall_n         <= '0;
      stall_err       <= 1'b0;
    end else begin
      case (state)
        IDLE, STALL: begin
          if (hazard) begin
            state   <= STALL;
            stall_n <= stall_n_nxt;
            if (stall_n_nxt == SN_MAX) begin
              stall_err <= 1'b1;
            end
          end else begin
            stall_n <= '0;
            if (id_xfer && (id_sel_op != PC_SEL_SEQ)) begin
              state           <= REDIRECT;
              sel_reg         <= id_sel_op;
              redirect_target <= id_target;
            end else begin
              state <= IDLE;
            end
          end
        end
        REDIRECT: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] redirect_cnt_q;
  logic [CNT_W-1:0] stall_cyc_cnt_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      redirect_cnt_q  <= '0;
      stall_cyc_cnt_q <= '0;
    end else begin
      if ((state == REDIRECT) && (redirect_cnt_q != '1)) begin
        redirect_cnt_q <= redirect_cnt_q + 1'b1;
      end
      if (stall_now && (stall_cyc_cnt_q != '1)) begin
        stall_cyc_cnt_q <= stall_cyc_cnt_q + 1'b1;
      end
    end
  end

  assign redirect_cnt  = redirect_cnt_q;
  assign stall_cyc_cnt = stall_cyc_cnt_q;
`else
  assign redirect_cnt  = '0;
  assign stall_cyc_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
module tb_branch_redirect_ctrl;

  localparam int unsigned MAX_STALL = 3;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned REG_W     = 5;

`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // {pc_sel, pc_write, ifid_write, ifid_flush, idex_bubble, stall_err}
  localparam logic [6:0] CTL_IDLE  = 7'b00_1100_0;
  localparam logic [6:0] CTL_STALL = 7'b00_0001_0;

  logic             Clk;
  logic             Reset;
  logic             id_xfer;
  logic [1:0]       id_sel_op;
  logic [31:0]      id_target;
  logic             id_uses_rt;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             ex_reg_write;
  logic [REG_W-1:0] ex_dst;
  logic             mem_mem_read;
  logic [REG_W-1:0] mem_dst;
  logic [1:0]       pc_sel;
  logic [31:0]      redirect_target;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             stall_err;
  logic [CNT_W-1:0] redirect_cnt;
  logic [CNT_W-1:0] stall_cyc_cnt;
  logic [6:0]       ctl;

  int checks = 0;
  int errors = 0;

  assign ctl = {pc_sel, pc_write, ifid_write, ifid_flush, idex_bubble, stall_err};

  branch_redirect_ctrl #(
    .MAX_STALL(MAX_STALL),
    .CNT_W    (CNT_W),
    .REG_W    (REG_W)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .id_xfer        (id_xfer),
    .id_sel_op      (id_sel_op),
    .id_target      (id_target),
    .id_uses_rt     (id_uses_rt),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .ex_reg_write   (ex_reg_write),
    .ex_dst         (ex_dst),
    .mem_mem_read   (mem_mem_read),
    .mem_dst        (mem_dst),
    .pc_sel         (pc_sel),
    .redirect_target(redirect_target),
    .pc_write       (pc_write),
    .ifid_write     (ifid_write),
    .ifid_flush     (ifid_flush),
    .idex_bubble    (idex_bubble),
    .stall_err      (stall_err),
    .redirect_cnt   (redirect_cnt),
    .stall_cyc_cnt  (stall_cyc_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Apply one cycle of inputs on the falling edge; outputs settle 1 time unit later.
  task automatic drive(input logic xfer, input logic [1:0] sel, input logic [31:0] tgt,
                       input logic urt, input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                       input logic exw, input logic [REG_W-1:0] exd,
                       input logic mrd, input logic [REG_W-1:0] md);
    @(negedge Clk);
    id_xfer = xfer; id_sel_op = sel; id_target = tgt; id_uses_rt = urt;
    id_rs = rs; id_rt = rt; ex_reg_write = exw; ex_dst = exd;
    mem_mem_read = mrd; mem_dst = md;
    #1;
  endtask

  task automatic drive_idle();
    drive(1'b0, 2'b00, 32'h0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  // Spec rule: operand r is unavailable if an EX writer or a MEM load targets it.
  function automatic bit unavailable(input logic [REG_W-1:0] r, input logic exw,
                                     input logic [REG_W-1:0] exd, input logic mrd,
                                     input logic [REG_W-1:0] md);
    return (r != 0) && ((exw && exd == r) || (mrd && md == r));
  endfunction

  task automatic test_reset();
    // Hazard present on the inputs; reset must still show the reset values.
    drive(1'b1, 2'b10, 32'h1234, 1'b0, 5'd4, 5'd0, 1'b1, 5'd4, 1'b0, 5'd0);
    Reset = 1'b1;
    #1;
    checks++;
    if (ctl !== CTL_IDLE) begin
      errors++; $display("FAIL reset_ctl: got %b exp %b", ctl, CTL_IDLE);
    end
    checks++;
    if (redirect_target !== 32'h0 || redirect_cnt !== '0 || stall_cyc_cnt !== '0) begin
      errors++;
      $display("FAIL reset_regs: tgt %h rc %0d sc %0d exp 0", redirect_target, redirect_cnt,
               stall_cyc_cnt);
    end
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_taken_branch();
    do_reset();
    drive(1'b1, 2'b10, 32'h0040_0020, 1'b1, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0);
    checks++;
    if (ctl !== CTL_IDLE) begin
      errors++; $display("FAIL beq_decide: got %b exp %b", ctl, CTL_IDLE);
    end
    drive_idle();
    checks++;
    if (ctl !== 7'b10_1111_0 || redirect_target !== 32'h0040_0020) begin
      errors++;
      $display("FAIL beq_redirect: got %b/%h exp 1011110/00400020", ctl, redirect_target);
    end
    drive_idle();
    checks++;
    if (ctl !== CTL_IDLE || redirect_cnt !== (STATS ? 16'd1 : 16'd0)) begin
      errors++; $display("FAIL beq_after: got %b rc %0d exp %b", ctl, redirect_cnt, CTL_IDLE);
    end
  endtask

  task automatic test_not_taken();
    do_reset();
    drive(1'b1, 2'b00, 32'h0040_0100, 1'b1, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0);
    drive_idle();
    checks++;
    if (ctl !== CTL_IDLE) begin
      errors++; $display("FAIL bne_nt: got %b exp %b", ctl, CTL_IDLE);
    end
  endtask

  task automatic test_load_stall();
    do_reset();
    // lw $8 in EX, then in MEM, then gone
    drive(1'b1, 2'b10, 32'h0040_0200, 1'b0, 5'd8, 5'd0, 1'b1, 5'd8, 1'b0, 5'd0);
    checks++;
    if (ctl !== CTL_STALL) begin
      errors++; $display("FAIL lw_stall1: got %b exp %b", ctl, CTL_STALL);
    end
    drive(1'b1, 2'b10, 32'h0040_0200, 1'b0, 5'd8, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8);
    checks++;
    if (ctl !== CTL_STALL) begin
      errors++; $display("FAIL lw_stall2: got %b exp %b", ctl, CTL_STALL);
    end
    drive(1'b1, 2'b10, 32'h0040_0200, 1'b0, 5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8);
    checks++;
    if (ctl !== CTL_IDLE) begin
      errors++; $display("FAIL lw_release: got %b exp %b", ctl, CTL_IDLE);
    end
    drive_idle();
    checks++;
    if (ctl !== 7'b10_1111_0 || redirect_target !== 32'h0040_0200 ||
        stall_cyc_cnt !== (STATS ? 16'd2 : 16'd0)) begin
      errors++;
      $display("FAIL lw_redirect: got %b/%h sc %0d", ctl, redirect_target, stall_cyc_cnt);
    end
  endtask

  task automatic test_jr_alu();
    do_reset();
    drive(1'b1, 2'b11, 32'h0040_0300, 1'b0, 5'd31, 5'd0, 1'b1, 5'd31, 1'b0, 5'd0);
    checks++;
    if (ctl !== CTL_STALL) begin
      errors++; $display("FAIL jr_stall: got %b exp %b", ctl, CTL_STALL);
    end
    // ALU result now in MEM: forwarded, no further stall
    drive(1'b1, 2'b11, 32'h0040_0300, 1'b0, 5'd31, 5'd0, 1'b0, 5'd0, 1'b0, 5'd31);
    checks++;
    if (ctl !== CTL_IDLE) begin
      errors++; $display("FAIL jr_release: got %b exp %b", ctl, CTL_IDLE);
    end
    drive_idle();
    checks++;
    if (ctl !== 7'b11_1111_0 || redirect_target !== 32'h0040_0300) begin
      errors++; $display("FAIL jr_redirect: got %b/%h exp 1111110", ctl, redirect_target);
    end
  endtask

  task automatic test_reg0_and_err();
    do_reset();
    drive(1'b1, 2'b10, 32'h0040_0400, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0);
    checks++;
    if (ctl !== CTL_IDLE) begin
      errors++; $display("FAIL r0_nostall: got %b exp %b", ctl, CTL_IDLE);
    end
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b10, 32'h0040_0500, 1'b1, 5'd2, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5);
      checks++;
      if (ctl !== CTL_STALL) begin
        errors++; $display("FAIL err_stall%0d: got %b exp %b", i, ctl, CTL_STALL);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive_idle();
      checks++;
      if (stall_err !== 1'b1) begin
        errors++; $display("FAIL err_sticky%0d: got %b exp 1", i, stall_err);
      end
    end
  endtask

  task automatic test_reset_in_redirect();
    do_reset();
    drive(1'b1, 2'b10, 32'h0040_0600, 1'b0, 5'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    drive_idle();
    checks++;
    if (ifid_flush !== 1'b1) begin
      errors++; $display("FAIL rr_inredirect: flush %b exp 1", ifid_flush);
    end
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (ctl !== CTL_IDLE || redirect_target !== 32'h0) begin
      errors++; $display("FAIL rr_async: got %b/%h exp %b/0", ctl, redirect_target, CTL_IDLE);
    end
    @(negedge Clk);
    Reset = 1'b0;
    drive(1'b1, 2'b01, 32'h0040_0700, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    drive_idle();
    checks++;
    if (ctl !== 7'b01_1111_0 || redirect_target !== 32'h0040_0700) begin
      errors++; $display("FAIL rr_jump: got %b/%h exp 0111110/00400700", ctl, redirect_target);
    end
  endtask

  task automatic test_random();
    bit          pend = 1'b0;
    logic [1:0]  msel = 2'b00;
    logic [31:0] mtgt = 32'h0;
    int          run  = 0;
    bit          merr = 1'b0;
    int          mrc  = 0;
    int          msc  = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic             xfer, urt, exw, mrd, haz;
      logic [1:0]       sel;
      logic [31:0]      tgt;
      logic [REG_W-1:0] rs, rt, exd, md;
      logic [6:0]       exp_ctl;
      logic [15:0]      exp_rc, exp_sc;
      xfer = ($urandom_range(0, 3) != 0);
      sel  = 2'($urandom_range(0, 3));
      tgt  = $urandom;
      urt  = 1'($urandom_range(0, 1));
      rs   = REG_W'($urandom_range(0, 3));
      rt   = REG_W'($urandom_range(0, 3));
      exw  = ($urandom_range(0, 2) == 0);
      exd  = REG_W'($urandom_range(0, 3));
      mrd  = ($urandom_range(0, 3) == 0);
      md   = REG_W'($urandom_range(0, 3));
      drive(xfer, sel, tgt, urt, rs, rt, exw, exd, mrd, md);
      haz = xfer && (unavailable(rs, exw, exd, mrd, md) ||
                     (urt && unavailable(rt, exw, exd, mrd, md)));
      if (pend)     exp_ctl = {msel, 4'b1111, merr};
      else if (haz) exp_ctl = {CTL_STALL[6:1], merr};
      else          exp_ctl = {CTL_IDLE[6:1], merr};
      exp_rc = STATS ? 16'(mrc) : 16'd0;
      exp_sc = STATS ? 16'(msc) : 16'd0;
      checks++;
      if (ctl !== exp_ctl || redirect_target !== mtgt) begin
        errors++;
        $display("FAIL rand%0d_out: got %b/%h exp %b/%h", i, ctl, redirect_target, exp_ctl, mtgt);
      end
      checks++;
      if (redirect_cnt !== exp_rc || stall_cyc_cnt !== exp_sc) begin
        errors++;
        $display("FAIL rand%0d_cnt: got %0d/%0d exp %0d/%0d", i, redirect_cnt, stall_cyc_cnt,
                 exp_rc, exp_sc);
      end
      // Advance the reference for the coming clock edge.
      if (pend) begin
        pend = 1'b0;
        mrc++;
        run = 0;
      end else if (haz) begin
        run++;
        msc++;
        if (run >= MAX_STALL) merr = 1'b1;
      end else begin
        run = 0;
        if (xfer && sel != 2'b00) begin
          pend = 1'b1; msel = sel; mtgt = tgt;
        end
      end
    end
  endtask

  initial begin
    Reset = 1'b1;
    id_xfer = 1'b0; id_sel_op = 2'b00; id_target = 32'h0; id_uses_rt = 1'b0;
    id_rs = '0; id_rt = '0; ex_reg_write = 1'b0; ex_dst = '0;
    mem_mem_read = 1'b0; mem_dst = '0;
    @(negedge Clk);
    Reset = 1'b0;
    test_reset();
    test_taken_branch();
    test_not_taken();
    test_load_stall();
    test_jr_alu();
    test_reg0_and_err();
    test_reset_in_redirect();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
